// File: rtl/router_fsm_np.sv
// Control FSM for a 1:N packet router: header decode, load sequencing, full stall and soft-reset abort.
// Optional WAIT_TILL_EMPTY timeout is enabled by defining ROUTER_WAIT_TMO_EN.
module router_fsm_np #(
  parameter int N_PORTS  = 3,
  parameter int ADDR_W   = 2,
  parameter int TMO_W    = 8,
  parameter int WAIT_TMO = 255
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               pkt_valid,
  input  logic [ADDR_W-1:0]  data_in,
  input  logic               fifo_full,
  input  logic [N_PORTS-1:0] fifo_empty,
  input  logic [N_PORTS-1:0] soft_reset,
  input  logic               parity_done,
  input  logic               low_packet_valid,
  output logic [ADDR_W-1:0]  dest_sel,
  output logic               detect_add,
  output logic               lfd_state,
  output logic               ld_state,
  output logic               laf_state,
  output logic               full_state,
  output logic               rst_int_reg,
  output logic               write_enb_reg,
  output logic               busy,
  output logic               wait_abort,
  output logic [2:0]         state_dbg_o
);

  localparam logic [2:0] DECODE_ADDRESS    = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA   = 3'd1;
  localparam logic [2:0] LOAD_DATA         = 3'd2;
  localparam logic [2:0] WAIT_TILL_EMPTY   = 3'd3;
  localparam logic [2:0] FIFO_FULL_STATE   = 3'd4;
  localparam logic [2:0] LOAD_AFTER_FULL   = 3'd5;
  localparam logic [2:0] LOAD_PARITY       = 3'd6;
  localparam logic [2:0] CHECK_PARITY_ERR  = 3'd7;

  localparam int NSEL = 1 << ADDR_W;

  // Source handshake: pkt_valid qualifies data_in; while busy=1 the source must
  // hold its current byte, and a byte is consumed on every edge with busy=0.

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [NSEL-1:0]   empty_pad;
  logic              hit;
  logic              e_da;
  logic              e_sel;
  logic              any_soft;
  logic              tmo_hit;

  // Pad the empty flags to the full address range so any address indexes safely.
  always_comb begin
    empty_pad = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      empty_pad[i] = fifo_empty[i];
    end
  end

  assign hit      = ({1'b0, data_in} < (ADDR_W + 1)'(N_PORTS));
  assign e_da     = empty_pad[data_in];
  assign e_sel    = empty_pad[dest_q];
  assign any_soft = |soft_reset;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && hit) begin
          dest_d  = data_in;
          state_d = e_da ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      WAIT_TILL_EMPTY: begin
        if (e_sel)        state_d = LOAD_FIRST_DATA;
        else if (tmo_hit) state_d = DECODE_ADDRESS;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_d = DECODE_ADDRESS;
        else if (low_packet_valid) state_d = LOAD_PARITY;
        else                       state_d = LOAD_DATA;
      end
      LOAD_PARITY:      state_d = CHECK_PARITY_ERR;
      CHECK_PARITY_ERR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:          state_d = DECODE_ADDRESS;
    endcase
    // Any port's soft reset aborts the packet; the latched destination is kept.
    if (any_soft) begin
      state_d = DECODE_ADDRESS;
      dest_d  = dest_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

`ifdef ROUTER_WAIT_TMO_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  // Counter is zero outside WAIT_TILL_EMPTY, so it starts from zero on entry.
  assign tmo_hit = (state_q == WAIT_TILL_EMPTY) && (cnt_q == TMO_W'(WAIT_TMO - 1));
  assign cnt_d   = ((state_q == WAIT_TILL_EMPTY) && !any_soft) ? cnt_q + 1'b1 : '0;
  assign abort_d = tmo_hit && !e_sel && !any_soft;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign wait_abort = abort_q;
`else
  logic unused_cfg;

  assign tmo_hit    = 1'b0;
  assign wait_abort = 1'b0;
  assign unused_cfg = ^{TMO_W[0], WAIT_TMO[0]};
`endif

  assign dest_sel      = dest_q;
  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np: a 3-port instance (WAIT_TMO=4) and a 4-port instance.
module tb_router_fsm_np;

  typedef enum logic [2:0] {
    ST_DA, ST_LFD, ST_LD, ST_WTE, ST_FFS, ST_LAF, ST_LP, ST_CPE
  } st_t;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    st_t        st;
    logic [1:0] dest;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic [3:0] fifo_empty4, soft_reset4;

  logic [1:0] dest_sel;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy, wait_abort;
  logic [2:0] unused_st3;

  logic [1:0] d4_dest;
  logic d4_da, d4_lfd, d4_ld, d4_laf, d4_ffs, d4_rst, d4_wen, d4_busy, d4_abort;
  logic [2:0] unused_st4;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  assign soft_reset4 = {1'b0, soft_reset};

  always #5 clock = ~clock;

  router_fsm_np #(.N_PORTS(3), .ADDR_W(2), .TMO_W(3), .WAIT_TMO(4)) u_dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .dest_sel(dest_sel), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy),
    .wait_abort(wait_abort), .state_dbg_o(unused_st3)
  );

  router_fsm_np #(.N_PORTS(4), .ADDR_W(2), .TMO_W(3), .WAIT_TMO(4)) u_dut4 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty4), .soft_reset(soft_reset4),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .dest_sel(d4_dest), .detect_add(d4_da), .lfd_state(d4_lfd),
    .ld_state(d4_ld), .laf_state(d4_laf), .full_state(d4_ffs),
    .rst_int_reg(d4_rst), .write_enb_reg(d4_wen), .busy(d4_busy),
    .wait_abort(d4_abort), .state_dbg_o(unused_st4)
  );

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, wait_abort}
  function automatic logic [8:0] model(input st_t s, input logic ab);
    model = {s == ST_DA, s == ST_LFD, s == ST_LD, s == ST_LAF, s == ST_FFS,
             s == ST_CPE, (s == ST_LD) || (s == ST_LP) || (s == ST_LAF),
             !((s == ST_DA) || (s == ST_LD)), ab};
  endfunction

  task automatic check3(input string name, input st_t s, input logic [1:0] d, input logic ab);
    logic [10:0] act, exp;
    act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, wait_abort, dest_sel};
    exp = {model(s, ab), d};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: outs+dest got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input st_t s, input logic [1:0] d);
    logic [10:0] act, exp;
    act = {d4_da, d4_lfd, d4_ld, d4_laf, d4_ffs, d4_rst, d4_wen, d4_busy, d4_abort, d4_dest};
    exp = {model(s, 1'b0), d};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: outs+dest got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic ff,
                       input logic [2:0] emp, input logic [2:0] sr,
                       input logic pd, input logic lpv);
    pkt_valid        = pv;
    data_in          = din;
    fifo_full        = ff;
    fifo_empty       = emp;
    soft_reset       = sr;
    parity_done      = pd;
    low_packet_valid = lpv;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // pv din full emp sr pd lpv -> state after the edge, dest_sel
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_DA,  2'd0});
    for (int i = 0; i < 5; i++)
      vecs.push_back(vec_t'{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_DA, 2'd0});
    vecs.push_back(vec_t'{1'b1, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, ST_WTE, 2'd1});
    vecs.push_back(vec_t'{1'b1, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, ST_WTE, 2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, ST_WTE, 2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, ST_LFD, 2'd1});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LD,  2'd1});
    for (int i = 0; i < 3; i++)
      vecs.push_back(vec_t'{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, ST_FFS, 2'd1});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LAF, 2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, ST_LP,  2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_CPE, 2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_DA,  2'd1});
    vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LFD, 2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LD,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LD,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, ST_FFS, 2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LAF, 2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LD,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, ST_FFS, 2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LAF, 2'd2});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b1, ST_DA,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LFD, 2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LD,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, ST_DA,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b100, 1'b0, 1'b0, ST_DA,  2'd2});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_DA,  2'd2});
    vecs.push_back(vec_t'{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LFD, 2'd0});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LD,  2'd0});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LP,  2'd0});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_CPE, 2'd0});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, ST_FFS, 2'd0});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_LAF, 2'd0});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, ST_DA,  2'd0});
    vecs.push_back(vec_t'{1'b1, 2'd1, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, ST_WTE, 2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b101, 3'b010, 1'b0, 1'b0, ST_DA,  2'd1});
    vecs.push_back(vec_t'{1'b1, 2'd2, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, ST_DA,  2'd1});
    vecs.push_back(vec_t'{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, ST_DA,  2'd1});

    resetn      = 1'b0;
    fifo_empty4 = 4'b1111;
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    #3;
    check3("reset3", ST_DA, 2'd0, 1'b0);
    check4("reset4", ST_DA, 2'd0);
    @(negedge clock);
    resetn = 1'b1;

    // 4-port instance: address 3 is a real port; the 3-port instance drops it.
    drive(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick; check4("p4_lfd", ST_LFD, 2'd3); check3("p3_drop", ST_DA, 2'd0, 1'b0);
    tick; check4("p4_ld", ST_LD, 2'd3);
    drive(1'b0, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick; check4("p4_lp", ST_LP, 2'd3);
    tick; check4("p4_cpe", ST_CPE, 2'd3);
    tick; check4("p4_da", ST_DA, 2'd3); check3("p3_still_da", ST_DA, 2'd0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].din, vecs[i].full, vecs[i].emp, vecs[i].sr,
            vecs[i].pd, vecs[i].lpv);
      tick;
      check3($sformatf("vec%0d", i), vecs[i].st, vecs[i].dest, 1'b0);
    end

    // Destination 1 never empties.
    drive(1'b1, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    tick; check3("tmo_enter", ST_WTE, 2'd1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick;
`ifdef ROUTER_WAIT_TMO_EN
      if (k < 4) check3($sformatf("tmo_wait%0d", k), ST_WTE, 2'd1, 1'b0);
      else       check3($sformatf("tmo_wait%0d", k), ST_DA, 2'd1, k == 4);
`else
      check3($sformatf("tmo_wait%0d", k), ST_WTE, 2'd1, 1'b0);
`endif
    end
    drive(1'b0, 2'd0, 1'b0, 3'b001, 3'b001, 1'b0, 1'b0);
    tick; check3("tmo_exit", ST_DA, 2'd1, 1'b0);

    // Destination empties in the very cycle the timeout would fire.
    drive(1'b1, 2'd1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    tick; check3("ewin_enter", ST_WTE, 2'd1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick; check3($sformatf("ewin_wait%0d", k), ST_WTE, 2'd1, 1'b0);
    end
    drive(1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    tick; check3("ewin_lfd", ST_LFD, 2'd1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick; check3("ewin_ld", ST_LD, 2'd1, 1'b0);
    tick; check3("ewin_lp", ST_LP, 2'd1, 1'b0);
    tick; check3("ewin_cpe", ST_CPE, 2'd1, 1'b0);
    tick; check3("ewin_da", ST_DA, 2'd1, 1'b0);

    // Asynchronous reset in the middle of LOAD_DATA.
    drive(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick; check3("arst_lfd", ST_LFD, 2'd2, 1'b0);
    tick; check3("arst_ld", ST_LD, 2'd2, 1'b0);
    #1 resetn = 1'b0;
    #1 check3("arst_now", ST_DA, 2'd0, 1'b0);
    check4("arst_now4", ST_DA, 2'd0);
    @(negedge clock);
    resetn = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick; check3("arst_after", ST_DA, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
